// File: rtl/psk_sample_packer.sv
// Packs LANES consecutive samples into one DAC word and buffers the words in a
// first-word-fall-through FIFO. The producer cannot be stalled, so a word that
// finds the FIFO full is dropped and a sticky overflow flag is raised.
module psk_sample_packer #(
   parameter int SAMPLE_W   = 12,
   parameter int LANES      = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          IN_VALID,
   input  logic [SAMPLE_W-1:0]           IN_DATA,
   input  logic                          IN_LAST,
   output logic                          OUT_VALID,
   input  logic                          OUT_READY,
   output logic [SAMPLE_W*LANES-1:0]     OUT_DATA,
   output logic [LANES-1:0]              OUT_KEEP,
   output logic                          OUT_LAST,
   output logic                          OVERFLOW,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

   localparam int WORD_W = SAMPLE_W * LANES;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
   localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);

   logic [LANE_W-1:0] r_lane;
   logic [WORD_W-1:0] r_pack;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic              r_overflow;

   logic [WORD_W-1:0] r_mem_data [FIFO_DEPTH];
   logic [LANES-1:0]  r_mem_keep [FIFO_DEPTH];
   logic              r_mem_last [FIFO_DEPTH];

   logic              w_commit;
   logic              w_pop;
   logic              w_full;
   logic              w_push;
   logic [WORD_W-1:0] w_commit_data;
   logic [LANES-1:0]  w_commit_keep;

   assign w_commit = IN_VALID && ((r_lane == LAST_LANE) || IN_LAST);
   assign w_full   = (r_level == FULL_LVL);
   assign w_pop    = OUT_VALID && OUT_READY;
   // A pop on the same edge frees the slot, so a commit into a full FIFO still lands.
   assign w_push   = w_commit && (!w_full || w_pop);

   // Lanes below the current one come from the pack register, the current lane
   // from the incoming sample, and everything above is forced to zero.
   always_comb begin
      w_commit_data = '0;
      w_commit_keep = '0;
      for (int i = 0; i < LANES; i++) begin
         if (LANE_W'(i) < r_lane) begin
            w_commit_data[i*SAMPLE_W +: SAMPLE_W] = r_pack[i*SAMPLE_W +: SAMPLE_W];
            w_commit_keep[i] = 1'b1;
         end else if (LANE_W'(i) == r_lane) begin
            w_commit_data[i*SAMPLE_W +: SAMPLE_W] = IN_DATA;
            w_commit_keep[i] = 1'b1;
         end
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others, independent of order.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_lane     <= '0;
         r_pack     <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (IN_VALID) begin
            if (w_commit) begin
               r_lane <= '0;
               r_pack <= '0;
            end else begin
               r_lane <= r_lane + LANE_W'(1);
               r_pack[r_lane*SAMPLE_W +: SAMPLE_W] <= IN_DATA;
            end
         end
         if (w_commit && !w_push) r_overflow <= 1'b1;
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // NOTE: the storage array has no reset; stale slots are never visible because
   // the outputs are masked whenever the level is zero.
   always_ff @(posedge CLK) begin
      if (w_push && !RESET) begin
         r_mem_data[r_wr_ptr] <= w_commit_data;
         r_mem_keep[r_wr_ptr] <= w_commit_keep;
         r_mem_last[r_wr_ptr] <= IN_LAST;
      end
   end

   assign OUT_VALID  = (r_level != '0);
   assign OUT_DATA   = OUT_VALID ? r_mem_data[r_rd_ptr] : '0;
   assign OUT_KEEP   = OUT_VALID ? r_mem_keep[r_rd_ptr] : '0;
   assign OUT_LAST   = OUT_VALID ? r_mem_last[r_rd_ptr] : 1'b0;
   assign OVERFLOW   = r_overflow;
   assign FIFO_LEVEL = r_level;

endmodule

// File: tb/tb_psk_sample_packer.sv
// Self-checking bench for psk_sample_packer: directed scenarios plus randomized
// gapped traffic, all compared against a queue-based word model.
module tb_psk_sample_packer;

   localparam int SAMPLE_W   = 12;
   localparam int LANES      = 4;
   localparam int FIFO_DEPTH = 8;

   typedef struct packed {
      logic [47:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        IN_VALID = 1'b0;
   logic [11:0] IN_DATA = '0;
   logic        IN_LAST = 1'b0;
   logic        OUT_VALID;
   logic        OUT_READY = 1'b0;
   logic [47:0] OUT_DATA;
   logic [3:0]  OUT_KEEP;
   logic        OUT_LAST;
   logic        OVERFLOW;
   logic [3:0]  FIFO_LEVEL;

   int n_cmp = 0;
   int n_err = 0;

   logic [11:0] m_part[$];
   word_t       m_fifo[$];
   logic        m_ovf = 1'b0;

   psk_sample_packer #(
      .SAMPLE_W(SAMPLE_W), .LANES(LANES), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_LAST(IN_LAST),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .OUT_DATA(OUT_DATA), .OUT_KEEP(OUT_KEEP), .OUT_LAST(OUT_LAST),
      .OVERFLOW(OVERFLOW), .FIFO_LEVEL(FIFO_LEVEL)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Compare every DUT output against the model head/level/flag.
   task automatic compare_outputs();
      word_t h;
      h = '0;
      if (m_fifo.size() != 0) h = m_fifo[0];
      check("out_valid", OUT_VALID, m_fifo.size() != 0);
      check("fifo_level", FIFO_LEVEL, m_fifo.size());
      check("overflow", OVERFLOW, m_ovf);
      check("out_data", OUT_DATA, h.data);
      check("out_keep", OUT_KEEP, h.keep);
      check("out_last", OUT_LAST, h.last);
   endtask

   // One clock: drive inputs, advance the model by the same edge, then compare.
   task automatic step(input logic v, input logic [11:0] d, input logic l,
                       input logic rdy, input logic rst);
      bit    full, pop, commit;
      word_t w;
      RESET = rst; IN_VALID = v; IN_DATA = d; IN_LAST = l; OUT_READY = rdy;
      commit = 0;
      w = '0;
      if (rst) begin
         m_part.delete();
         m_fifo.delete();
         m_ovf = 1'b0;
      end else begin
         full = (m_fifo.size() == FIFO_DEPTH);
         pop  = (m_fifo.size() != 0) && rdy;
         if (v) begin
            m_part.push_back(d);
            if (m_part.size() == LANES || l) begin
               for (int i = 0; i < m_part.size(); i++) begin
                  w.data[i*12 +: 12] = m_part[i];
                  w.keep[i] = 1'b1;
               end
               w.last = l;
               m_part.delete();
               commit = 1;
            end
         end
         if (pop) void'(m_fifo.pop_front());
         if (commit) begin
            if (!full || pop) m_fifo.push_back(w);
            else m_ovf = 1'b1;
         end
      end
      @(posedge CLK);
      #1;
      compare_outputs();
      @(negedge CLK);
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, 12'h000, 1'b0, rdy, 1'b0);
   endtask

   initial begin
      // Reset state
      step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
      check("reset_valid", OUT_VALID, 1'b0);
      check("reset_level", FIFO_LEVEL, 4'd0);

      // Eight consecutive samples, consumer always ready
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 12'(i), 1'b0, 1'b1, 1'b0);
         if (i == 4) check("word0_data", OUT_DATA, 48'h004003002001);
         if (i == 8) begin
            check("word1_data", OUT_DATA, 48'h008007006005);
            check("word1_keep", OUT_KEEP, 4'hF);
            check("word1_last", OUT_LAST, 1'b0);
         end
      end
      idle(2, 1'b1);

      // Short final word closed by IN_LAST
      for (int i = 1; i <= 6; i++) step(1'b1, 12'hA00 + 12'(i), i == 6, 1'b1, 1'b0);
      check("lastword_data", OUT_DATA, 48'h000000A06A05);
      check("lastword_keep", OUT_KEEP, 4'h3);
      check("lastword_last", OUT_LAST, 1'b1);
      step(1'b1, 12'hB01, 1'b1, 1'b1, 1'b0);
      check("lane0_data", OUT_DATA, 48'h000000000B01);
      check("lane0_keep", OUT_KEEP, 4'h1);
      idle(2, 1'b1);

      // Overflow: 40 samples into a stalled FIFO, then drain
      for (int i = 0; i < 40; i++) step(1'b1, 12'h100 + 12'(i), 1'b0, 1'b0, 1'b0);
      check("ovf_level", FIFO_LEVEL, 4'd8);
      check("ovf_set", OVERFLOW, 1'b1);
      check("ovf_head", OUT_DATA, 48'h103102101100);
      idle(10, 1'b1);
      check("ovf_sticky", OVERFLOW, 1'b1);

      // Full FIFO with simultaneous commit and pop
      step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 32; i++) step(1'b1, 12'h200 + 12'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 12'h300 + 12'(i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 12'h303, 1'b0, 1'b1, 1'b0);
      check("fullpop_level", FIFO_LEVEL, 4'd8);
      check("fullpop_ovf", OVERFLOW, 1'b0);
      idle(7, 1'b1);
      check("fullpop_tail", OUT_DATA, 48'h303302301300);
      idle(2, 1'b1);

      // Random gaps, random consumer stalls, occasional short pulses
      for (int n = 0; n < 300; n++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++)
            step(1'b0, 12'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
         step(1'b1, 12'($urandom), $urandom_range(0, 7) == 0,
              1'($urandom_range(0, 1)), 1'b0);
      end
      idle(12, 1'b1);

      // Reset mid-word with three words buffered
      for (int i = 0; i < 14; i++) step(1'b1, 12'h400 + 12'(i), 1'b0, 1'b0, 1'b0);
      check("prerst_level", FIFO_LEVEL, 4'd3);
      step(1'b1, 12'h4FF, 1'b0, 1'b0, 1'b1);
      check("rst_valid", OUT_VALID, 1'b0);
      check("rst_level", FIFO_LEVEL, 4'd0);
      for (int i = 1; i <= 4; i++) step(1'b1, 12'hC00 + 12'(i), 1'b0, 1'b0, 1'b0);
      check("postrst_data", OUT_DATA, 48'hC04C03C02C01);
      check("postrst_keep", OUT_KEEP, 4'hF);
      idle(3, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/psk_sample_packer.md
# psk_sample_packer

Output-side packing stage of the PSK synthesis chain. Consumes the 12-bit sample stream produced by `output_reg` (one sample per `READY` strobe), groups four consecutive samples into one 48-bit DAC word, and buffers words in a small first-word-fall-through FIFO. The DAC/serialiser interface drains it with a valid/ready handshake. The sample producer cannot be stalled, so overflow is detected and flagged rather than back-pressured.

## Interface
Parameters:
- `SAMPLE_W`, 12, sample width (matches ROM/output_reg width)
- `LANES`, 4, samples per output word
- `FIFO_DEPTH`, 8, word slots; power of two, ≥2

Ports:
- `CLK`  in  1  system clock; all logic on the rising edge
- `RESET`  in  1  synchronous, active-high reset
- `IN_VALID`  in  1  sample strobe (driven from `output_reg` `READY`)
- `IN_DATA`  in  SAMPLE_W  sample value (from `output_reg` `OUTPUT`)
- `IN_LAST`  in  1  qualifies the final sample of a pulse; ignored when `IN_VALID`=0
- `OUT_VALID`  out  1  FIFO head word valid
- `OUT_READY`  in  1  consumer accepts head word
- `OUT_DATA`  out  SAMPLE_W*LANES  packed word; lane i at bits [i*SAMPLE_W +: SAMPLE_W], lane 0 = earliest sample
- `OUT_KEEP`  out  LANES  per-lane valid mask of head word
- `OUT_LAST`  out  1  head word closes a pulse
- `OVERFLOW`  out  1  sticky: a word was dropped on full FIFO
- `FIFO_LEVEL`  out  clog2(FIFO_DEPTH)+1  words currently stored

## Operation
- Lane counter `lane` (0..LANES-1) and pack register hold the partial word.
- On edge with `IN_VALID`=1: sample stored into lane `lane`.
  - If `lane`=LANES-1 or `IN_LAST`=1: word commit. The commit word is the pack register merged with the incoming sample. Lanes above `lane` are forced to 0, KEEP = lanes 0..`lane` set, LAST = `IN_LAST`. `lane`←0 and the pack register clears.
  - Otherwise `lane`←`lane`+1.
- Commit writes the FIFO on the same edge, unless the FIFO is full and no pop occurs on that edge. In that case the word is discarded, `OVERFLOW`←1, and `lane` still returns to 0.
- Simultaneous commit and pop while full: both happen; level unchanged, no overflow.
- Pop: `OUT_VALID`&&`OUT_READY` at an edge removes the head; `OUT_READY` while `OUT_VALID`=0 has no effect.
- `OUT_VALID` = (level≠0). `OUT_DATA`, `OUT_KEEP`, `OUT_LAST` show the head entry when valid and are forced to 0 when not valid.
- `OVERFLOW` clears only on `RESET`.
- Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Level is tracked separately, range 0..FIFO_DEPTH.

## Timing
- Reset, synchronous and dominant over all other inputs at that edge: `lane`=0, pack register 0, pointers 0, `FIFO_LEVEL`=0, `OUT_VALID`=0, `OUT_DATA`=0, `OUT_KEEP`=0, `OUT_LAST`=0, `OVERFLOW`=0.
- A reset mid-word or mid-pulse discards the partial word and all buffered words. The first `IN_VALID` after reset lands in lane 0.
- Latency: the word completes on the edge that captures its last sample. `OUT_VALID` and head data are visible in the cycle after that edge (1 cycle), provided the FIFO was empty.
- Throughput: one sample per cycle in; one word per cycle out.
- `OUT_DATA`/`OUT_KEEP`/`OUT_LAST` remain stable while `OUT_VALID`=1 and `OUT_READY`=0.
- `FIFO_LEVEL` is registered and reflects the edge's push/pop net effect (+1, −1, 0).

## Test plan
- Reset then 8 consecutive samples 0x001..0x008, `OUT_READY`=1: words 0x004003002001 and 0x008007006005 appear, `OUT_KEEP`=0xF, `OUT_LAST`=0, each 1 cycle after its 4th sample edge.
- 6 samples 0xA01..0xA06 with `IN_LAST` on the 6th: second word 0x000000A06A05, `OUT_KEEP`=0x3, `OUT_LAST`=1. The next sample packs into lane 0.
- `OUT_READY`=0, stream 40 samples: `FIFO_LEVEL` reaches 8, the 9th and 10th words are dropped, `OVERFLOW`=1. After draining, the 8 stored words are intact and in order, and `OVERFLOW` stays 1.
- FIFO full, completing sample and `OUT_READY`=1 on the same edge: level stays 8, `OVERFLOW` stays 0, and the new word emerges last.
- `IN_VALID` gaps (random 0–3 idle cycles) with `OUT_READY` toggling: output word sequence equals the gap-free reference, with no duplication while stalled.
- Assert `RESET` after 2 samples with 3 words buffered: next cycle `OUT_VALID`=0 and level 0. The following 4 samples form a full clean word.
